// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp bundle and lamp decode for the
// parametrised two-way intersection controller.
//   state_t      : 3-bit phase encoding (also exported on the debug port)
//   lamps_t      : one bit per lamp driver
//   decode_lamps : Moore decode of a phase (plus flash blink) into lamps
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_EW = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_NS = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  typedef struct packed {
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
    logic walk;
  } lamps_t;

  function automatic lamps_t decode_lamps(input state_t s, input logic blink);
    lamps_t l;
    l = '0;
    case (s)
      NS_G:    begin l.ns_g = 1'b1; l.ew_r = 1'b1; end
      NS_Y:    begin l.ns_y = 1'b1; l.ew_r = 1'b1; end
      EW_G:    begin l.ew_g = 1'b1; l.ns_r = 1'b1; end
      EW_Y:    begin l.ew_y = 1'b1; l.ns_r = 1'b1; end
      AR_EW,
      AR_NS:   begin l.ns_r = 1'b1; l.ew_r = 1'b1; end
      WALK:    begin l.ns_r = 1'b1; l.ew_r = 1'b1; l.walk = 1'b1; end
      FLASH:   begin l.ns_y = blink; l.ew_y = blink; end
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: tick counter for the current phase.
//   clk, rst : clock, synchronous active-high reset
//   tick     : timebase strobe; each clk with tick=1 counts once
//   clr      : restart counting from 0 (asserted on every phase change)
//   dur      : phase length in ticks (1 .. 2^CNT_W)
//   done     : tick that completes the phase (tick & cnt == dur-1)
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           clr,
  input  logic [CNT_W:0] dur,
  output logic           done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   last;

  // dur is one bit wider so that 2^CNT_W is representable; dur-1 then
  // always fits in cnt.
  assign last = dur - 1'b1;
  assign done = tick && ({1'b0, cnt} == last);

  // Wrapping on done only matters in phases that ignore expiry (FLASH);
  // everywhere else clr restarts the count in the same cycle anyway.
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= done ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_light_param.sv
// traffic_light_param: NS/EW intersection controller with parametrised
// phase lengths, latched pedestrian WALK insertion and night flash mode.
//   clk, rst          : clock, synchronous active-high reset
//   tick              : timebase strobe from the board prescaler
//   ped_req           : pedestrian button (pulse or level), latched
//   flash_en          : night flash request, honoured in all-red phases
//   ns_g/ns_y/ns_r    : north-south lamps (registered)
//   ew_g/ew_y/ew_r    : east-west lamps (registered)
//   ped_walk          : walk lamp (registered)
//   phase             : current state encoding, debug
module traffic_light_param
  import traffic_pkg::*;
#(
  parameter int G_TICKS    = 5,
  parameter int Y_TICKS    = 2,
  parameter int AR_TICKS   = 1,
  parameter int WALK_TICKS = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W:0] G_D  = (CNT_W+1)'(G_TICKS);
  localparam logic [CNT_W:0] Y_D  = (CNT_W+1)'(Y_TICKS);
  localparam logic [CNT_W:0] AR_D = (CNT_W+1)'(AR_TICKS);
  localparam logic [CNT_W:0] WK_D = (CNT_W+1)'(WALK_TICKS);

  state_t         state, state_nxt;
  logic           ped_pend, next_ew, blink;
  logic           next_ew_nxt, blink_nxt;
  logic           ped_any, done, clr;
  logic [CNT_W:0] dur;
  lamps_t         lamps;

  always_comb begin
    case (state)
      NS_G, EW_G:   dur = G_D;
      NS_Y, EW_Y:   dur = Y_D;
      AR_EW, AR_NS: dur = AR_D;
      WALK:         dur = WK_D;
      default:      dur = (CNT_W+1)'(1);
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .clr  (clr),
    .dur  (dur),
    .done (done)
  );

  // A press on the very edge the yellow expires still counts.
  assign ped_any = ped_pend | ped_req;

  always_comb begin
    state_nxt   = state;
    next_ew_nxt = next_ew;
    blink_nxt   = blink;
    if (tick) begin
      case (state)
        NS_G: if (done) state_nxt = NS_Y;
        NS_Y: if (done) begin
          if (ped_any) begin state_nxt = WALK; next_ew_nxt = 1'b1; end
          else           state_nxt = AR_EW;
        end
        AR_EW: begin
          // Flash preempts the clearance regardless of how far it has run.
          if (flash_en)  begin state_nxt = FLASH; blink_nxt = 1'b1; end
          else if (done) state_nxt = EW_G;
        end
        EW_G: if (done) state_nxt = EW_Y;
        EW_Y: if (done) begin
          if (ped_any) begin state_nxt = WALK; next_ew_nxt = 1'b0; end
          else           state_nxt = AR_NS;
        end
        AR_NS: begin
          if (flash_en)  begin state_nxt = FLASH; blink_nxt = 1'b1; end
          else if (done) state_nxt = NS_G;
        end
        WALK: if (done) state_nxt = next_ew ? AR_EW : AR_NS;
        FLASH: begin
          if (!flash_en) state_nxt = AR_NS;
          else           blink_nxt = ~blink;
        end
        default: state_nxt = NS_G;
      endcase
    end
  end

  // Every transition changes state, so a change is exactly a phase entry.
  assign clr = (state_nxt != state);

  // Lamps are decoded from the next state so they are registered alongside
  // it and change on the same edge, without an extra cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NS_G;
      ped_pend <= 1'b0;
      next_ew  <= 1'b0;
      blink    <= 1'b0;
      lamps    <= decode_lamps(NS_G, 1'b0);
    end else begin
      state    <= state_nxt;
      next_ew  <= next_ew_nxt;
      blink    <= blink_nxt;
      lamps    <= decode_lamps(state_nxt, blink_nxt);
      // WALK entry consumes the request; later presses latch for next time.
      if (state_nxt == WALK && state != WALK) ped_pend <= 1'b0;
      else if (ped_req)                       ped_pend <= 1'b1;
    end
  end

  assign ns_g     = lamps.ns_g;
  assign ns_y     = lamps.ns_y;
  assign ns_r     = lamps.ns_r;
  assign ew_g     = lamps.ew_g;
  assign ew_y     = lamps.ew_y;
  assign ew_r     = lamps.ew_r;
  assign ped_walk = lamps.walk;
  assign phase    = state;

endmodule

// File: tb/tb_traffic_light_param.sv
// Bench for traffic_light_param: a directed vector table, a slow-tick full
// cycle sequence, and a long randomized run against a tick-level model that
// tracks remaining ticks per phase.
module tb_traffic_light_param;

  logic       clk = 1'b0;
  logic       rst, tick, ped_req, flash_en;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  traffic_light_param dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .ns_g     (ns_g),
    .ns_y     (ns_y),
    .ns_r     (ns_r),
    .ew_g     (ew_g),
    .ew_y     (ew_y),
    .ew_r     (ew_r),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  // Lamp bundle order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  localparam logic [6:0] L_NSG = 7'b1000010;
  localparam logic [6:0] L_NSY = 7'b0100010;
  localparam logic [6:0] L_AR  = 7'b0010010;
  localparam logic [6:0] L_EWG = 7'b0011000;
  localparam logic [6:0] L_EWY = 7'b0010100;
  localparam logic [6:0] L_WK  = 7'b0010011;
  localparam logic [6:0] L_FL1 = 7'b0100100;
  localparam logic [6:0] L_FL0 = 7'b0000000;

  // ---------------- reference model ----------------
  // Phases: 0 NS green, 1 NS yellow, 2 clear->EW, 3 EW green, 4 EW yellow,
  // 5 clear->NS, 6 walk, 7 flash. m_left = ticks still to run in this phase.
  int         DUR [8] = '{5, 2, 1, 5, 2, 1, 3, 1};
  logic [6:0] LAMP[7] = '{L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR, L_WK};
  int   m_ph, m_left;
  logic m_pend, m_to_ew, m_blink;

  task automatic mstep(input logic r, input logic t, input logic q, input logic f);
    int  nx;
    logic req, walked;
    if (r) begin
      m_ph = 0; m_left = DUR[0]; m_pend = 0; m_to_ew = 0; m_blink = 0;
      return;
    end
    req    = m_pend | q;
    walked = 0;
    if (t) begin
      if ((m_ph == 2 || m_ph == 5) && f) begin
        m_ph = 7; m_blink = 1;
      end else if (m_ph == 7) begin
        if (!f) begin m_ph = 5; m_left = DUR[5]; end
        else m_blink = !m_blink;
      end else if (m_left > 1) begin
        m_left--;
      end else begin
        case (m_ph)
          1:       if (req) begin nx = 6; m_to_ew = 1; end else nx = 2;
          4:       if (req) begin nx = 6; m_to_ew = 0; end else nx = 5;
          5:       nx = 0;
          6:       nx = m_to_ew ? 2 : 5;
          default: nx = m_ph + 1;
        endcase
        walked = (nx == 6);
        m_ph   = nx;
        m_left = DUR[nx];
      end
    end
    if (walked) m_pend = 0;
    else if (q) m_pend = 1;
  endtask

  function automatic logic [6:0] m_lamps();
    if (m_ph == 7) return m_blink ? L_FL1 : L_FL0;
    return LAMP[m_ph];
  endfunction

  function automatic logic [6:0] act_lamps();
    return {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [2:0] exp_ph, input logic [6:0] exp_l);
    n_checks++;
    if (phase !== exp_ph || act_lamps() !== exp_l) begin
      n_errors++;
      $display("FAIL %s: phase=%0d lamps=%b, required phase=%0d lamps=%b",
               name, phase, act_lamps(), exp_ph, exp_l);
    end
  endtask

  // Apply inputs for one clk, step the model on the same edge, sample at +1.
  task automatic cyc(input logic r, input logic t, input logic q, input logic f);
    rst = r; tick = t; ped_req = q; flash_en = f;
    @(posedge clk);
    mstep(r, t, q, f);
    #1;
  endtask

  typedef struct {
    logic       r, t, q, f;
    logic [2:0] ph;
    logic [6:0] lp;
  } vec_t;

  vec_t tbl[26];
  int   exp_slow[16] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 0};

  function automatic vec_t mk(input logic r, input logic t, input logic q,
                              input logic f, input logic [2:0] ph, input logic [6:0] lp);
    vec_t v;
    v.r = r; v.t = t; v.q = q; v.f = f; v.ph = ph; v.lp = lp;
    return v;
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0; flash_en = 1'b0;

    // Directed table: tick held high except row 3.
    tbl[0]  = mk(1, 0, 0, 0, 3'd0, L_NSG);  // reset cycle 1
    tbl[1]  = mk(1, 0, 0, 0, 3'd0, L_NSG);  // reset cycle 2
    tbl[2]  = mk(0, 1, 0, 0, 3'd0, L_NSG);  // tick 1
    tbl[3]  = mk(0, 0, 0, 0, 3'd0, L_NSG);  // no tick: hold
    tbl[4]  = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[5]  = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[6]  = mk(0, 1, 0, 0, 3'd0, L_NSG);  // tick 4
    tbl[7]  = mk(0, 1, 0, 0, 3'd1, L_NSY);  // tick 5 -> yellow
    tbl[8]  = mk(0, 1, 0, 0, 3'd1, L_NSY);
    tbl[9]  = mk(0, 1, 1, 0, 3'd6, L_WK);   // press on expiry edge -> walk
    tbl[10] = mk(0, 1, 0, 0, 3'd6, L_WK);
    tbl[11] = mk(0, 1, 0, 0, 3'd6, L_WK);
    tbl[12] = mk(0, 1, 0, 0, 3'd2, L_AR);   // walk done -> clear to EW
    tbl[13] = mk(0, 1, 0, 1, 3'd7, L_FL1);  // flash in all-red
    tbl[14] = mk(0, 1, 0, 1, 3'd7, L_FL0);
    tbl[15] = mk(0, 1, 0, 0, 3'd5, L_AR);   // flash off -> clear to NS
    tbl[16] = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[17] = mk(0, 1, 1, 0, 3'd0, L_NSG);  // latch a request
    tbl[18] = mk(1, 1, 0, 0, 3'd0, L_NSG);  // reset drops it
    tbl[19] = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[20] = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[21] = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[22] = mk(0, 1, 0, 0, 3'd0, L_NSG);
    tbl[23] = mk(0, 1, 0, 0, 3'd1, L_NSY);
    tbl[24] = mk(0, 1, 0, 0, 3'd1, L_NSY);
    tbl[25] = mk(0, 1, 0, 0, 3'd2, L_AR);   // no walk after reset

    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].q, tbl[i].f);
      check($sformatf("vec%0d", i), tbl[i].ph, tbl[i].lp);
    end

    // Slow timebase: tick every 20 clk, one full 16-tick cycle.
    cyc(1, 0, 0, 0);
    check("slow_reset", 3'd0, L_NSG);
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 19; j++) begin
        cyc(0, 0, 0, 0);
        check($sformatf("slow_hold%0d_%0d", k, j), m_ph[2:0], m_lamps());
      end
      cyc(0, 1, 0, 0);
      check($sformatf("slow_tick%0d", k + 1), 3'(exp_slow[k]), m_lamps());
    end

    // Slow timebase with a press during NS green tick 2, then a second
    // press during WALK; model decides the rest.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 19; j++) begin
        cyc(0, 0, (k == 1 && j == 5) || (k == 9 && j == 3), 0);
        check($sformatf("ped_hold%0d", k), m_ph[2:0], m_lamps());
      end
      cyc(0, 1, 0, 0);
      check($sformatf("ped_tick%0d", k), m_ph[2:0], m_lamps());
    end

    // Randomized run against the model.
    begin
      logic f = 1'b0;
      cyc(1, 0, 0, 0);
      for (int n = 0; n < 6000; n++) begin
        if ($urandom_range(0, 79) == 0) f = ~f;
        cyc($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 24) == 0, f);
        check($sformatf("rand%0d", n), m_ph[2:0], m_lamps());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
